// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file constants for decode, writeback and the write scoreboard.
package reg_scoreboard_pkg;
   localparam int NREG    = 32;
   localparam int ADDR_W  = 5;
   localparam int CNT_W   = 2;
   localparam int MAX_OUT = 4;
   localparam int OUT_W   = 3;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

   // JAL links into $31 regardless of the rd field, matching the writeback path.
   function automatic logic [ADDR_W-1:0] eff_dest(input logic is_jal, input logic [ADDR_W-1:0] rd);
      return is_jal ? REG_RA : rd;
   endfunction
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down with clear and nonzero flag.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nz_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign nz_o  = (cnt_q != '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Decode-side guard: counts in-flight register writes and stalls issue on RAW or capacity hazards.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              iss_valid_i,
   input  logic              iss_regwrite_i,
   input  logic              iss_isjal_i,
   input  logic [ADDR_W-1:0] iss_rd_i,
   input  logic [ADDR_W-1:0] iss_rs_i,
   input  logic [ADDR_W-1:0] iss_rt_i,
   input  logic              iss_use_rs_i,
   input  logic              iss_use_rt_i,
   input  logic              wb_valid_i,
   input  logic [ADDR_W-1:0] wb_rd_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              iss_accept_o,
   output logic [NREG-1:0]   busy_o,
   output logic [OUT_W-1:0]  outstanding_o,
   output logic              err_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt [NREG];
   logic [NREG-1:0]  nz;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic             err_q, err_d;

   logic [ADDR_W-1:0] ed;
   logic ew, haz_rs, haz_rt, dest_full, out_full;
   logic inc, dec, underflow;

   assign ed = eff_dest(iss_isjal_i, iss_rd_i);
   assign ew = iss_regwrite_i && (ed != REG_ZERO);

   // Stall looks only at registered counters: no same-cycle writeback bypass.
   assign haz_rs    = iss_use_rs_i && (iss_rs_i != REG_ZERO) && (cnt[iss_rs_i] != '0);
   assign haz_rt    = iss_use_rt_i && (iss_rt_i != REG_ZERO) && (cnt[iss_rt_i] != '0);
   assign dest_full = ew && (cnt[ed] == CNT_MAX);
   assign out_full  = ew && (outstanding_q == OUT_W'(MAX_OUT));

   assign stall_o      = iss_valid_i && (haz_rs || haz_rt || dest_full || out_full);
   assign iss_accept_o = iss_valid_i && !stall_o;

   assign inc       = iss_accept_o && ew;
   assign dec       = wb_valid_i && (wb_rd_i != REG_ZERO) && (cnt[wb_rd_i] != '0);
   assign underflow = wb_valid_i && (wb_rd_i != REG_ZERO) && (cnt[wb_rd_i] == '0);

   assign cnt[0] = '0;
   assign nz[0]  = 1'b0;

   for (genvar i = 1; i < NREG; i++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (flush_i),
         .inc_i (inc && (ed == ADDR_W'(i))),
         .dec_i (dec && (wb_rd_i == ADDR_W'(i))),
         .cnt_o (cnt[i]),
         .nz_o  (nz[i])
      );
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (flush_i) begin
         outstanding_d = '0;
      end else begin
         outstanding_d = outstanding_q + OUT_W'(inc) - OUT_W'(dec);
      end
      err_d = err_q || underflow;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   assign busy_o        = nz;
   assign outstanding_o = outstanding_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed vector table, hand-written reset sequence, random run vs. counter model.
module tb_reg_scoreboard;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        iss_valid_i, iss_regwrite_i, iss_isjal_i;
   logic [4:0]  iss_rd_i, iss_rs_i, iss_rt_i;
   logic        iss_use_rs_i, iss_use_rt_i;
   logic        wb_valid_i;
   logic [4:0]  wb_rd_i;
   logic        flush_i;
   logic        stall_o, iss_accept_o, err_o;
   logic [31:0] busy_o;
   logic [2:0]  outstanding_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   reg_scoreboard dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .iss_valid_i(iss_valid_i), .iss_regwrite_i(iss_regwrite_i), .iss_isjal_i(iss_isjal_i),
      .iss_rd_i(iss_rd_i), .iss_rs_i(iss_rs_i), .iss_rt_i(iss_rt_i),
      .iss_use_rs_i(iss_use_rs_i), .iss_use_rt_i(iss_use_rt_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
      .stall_o(stall_o), .iss_accept_o(iss_accept_o), .busy_o(busy_o),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic v, rw, jal;
      logic [4:0] rd, rs, rt;
      logic urs, urt, wv;
      logic [4:0] wrd;
      logic fl;
      logic e_stall, e_acc;
      logic [31:0] e_busy;
      logic [2:0] e_out;
      logic e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, rw, jal, input int rd, rs, rt, input logic urs, urt, wv,
                               input int wrd, input logic fl, e_stall, e_acc,
                               input logic [31:0] e_busy, input int e_out, input logic e_err);
      vec_t r;
      r.v = v; r.rw = rw; r.jal = jal; r.rd = 5'(rd); r.rs = 5'(rs); r.rt = 5'(rt);
      r.urs = urs; r.urt = urt; r.wv = wv; r.wrd = 5'(wrd); r.fl = fl;
      r.e_stall = e_stall; r.e_acc = e_acc; r.e_busy = e_busy; r.e_out = 3'(e_out); r.e_err = e_err;
      return r;
   endfunction

   task automatic idle_inputs();
      iss_valid_i = 0; iss_regwrite_i = 0; iss_isjal_i = 0;
      iss_rd_i = 0; iss_rs_i = 0; iss_rt_i = 0; iss_use_rs_i = 0; iss_use_rt_i = 0;
      wb_valid_i = 0; wb_rd_i = 0; flush_i = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1;
      @(posedge clk_i); #1;
      rst_i = 0;
      #1;
   endtask

   // Reference model: plain per-register pending counts.
   int  m_cnt[32];
   int  m_out;
   bit  m_err;

   task automatic model_clear();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_out = 0;
      m_err = 0;
   endtask

   function automatic bit model_stall();
      int ed;
      bit ew, hz;
      ed = iss_isjal_i ? 31 : int'(iss_rd_i);
      ew = iss_regwrite_i && ed != 0;
      hz = (iss_use_rs_i && iss_rs_i != 0 && m_cnt[iss_rs_i] > 0) ||
           (iss_use_rt_i && iss_rt_i != 0 && m_cnt[iss_rt_i] > 0) ||
           (ew && m_cnt[ed] == 3) || (ew && m_out == 4);
      return iss_valid_i && hz;
   endfunction

   task automatic model_step(input bit acc);
      int ed;
      int nxt[32];
      int w;
      ed = iss_isjal_i ? 31 : int'(iss_rd_i);
      w  = int'(wb_rd_i);
      if (wb_valid_i && w != 0 && m_cnt[w] == 0) m_err = 1;
      nxt = m_cnt;
      if (acc && iss_regwrite_i && ed != 0) begin nxt[ed]++; m_out++; end
      if (wb_valid_i && w != 0 && m_cnt[w] > 0) begin nxt[w]--; m_out--; end
      m_cnt = nxt;
      if (flush_i) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_out = 0;
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b = '0;
      for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
      return b;
   endfunction

   initial begin
      rst_i = 1;
      idle_inputs();
      #2;
      chk("async_reset_busy", busy_o, 32'h0);
      chk("async_reset_out", 32'(outstanding_o), 32'h0);
      do_reset();
      chk("reset_busy", busy_o, 32'h0);
      chk("reset_out", 32'(outstanding_o), 0);
      chk("reset_err", 32'(err_o), 0);
      chk("reset_stall", 32'(stall_o), 0);

      //        v rw jal rd rs rt urs urt wv wrd fl  stall acc busy          out err
      vecs.push_back(mk(1,1,0, 8, 1, 2, 1,1, 0, 0,0,  0,1, 32'h0000_0100, 1,0));
      vecs.push_back(mk(1,0,0, 0, 8, 0, 1,0, 0, 0,0,  1,0, 32'h0000_0100, 1,0));
      vecs.push_back(mk(1,0,0, 0, 8, 0, 1,0, 1, 8,0,  1,0, 32'h0000_0000, 0,0));
      vecs.push_back(mk(1,0,0, 0, 8, 0, 1,0, 0, 0,0,  0,1, 32'h0000_0000, 0,0));
      vecs.push_back(mk(1,1,1, 5, 0, 0, 0,0, 0, 0,0,  0,1, 32'h8000_0000, 1,0));
      vecs.push_back(mk(1,1,0, 0, 0, 0, 0,0, 0, 0,0,  0,1, 32'h8000_0000, 1,0));
      vecs.push_back(mk(0,0,0, 0, 0, 0, 0,0, 1,31,0,  0,0, 32'h0000_0000, 0,0));
      vecs.push_back(mk(1,1,0, 9, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_0200, 1,0));
      vecs.push_back(mk(1,1,0, 9, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_0200, 2,0));
      vecs.push_back(mk(1,1,0, 9, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_0200, 3,0));
      vecs.push_back(mk(1,1,0, 9, 0, 0, 0,0, 0, 0,0,  1,0, 32'h0000_0200, 3,0));
      vecs.push_back(mk(1,1,0, 9, 0, 0, 0,0, 1, 9,0,  1,0, 32'h0000_0200, 2,0));
      vecs.push_back(mk(1,1,0, 9, 0, 0, 0,0, 1, 9,0,  0,1, 32'h0000_0200, 2,0));
      vecs.push_back(mk(0,0,0, 0, 0, 0, 0,0, 1, 9,0,  0,0, 32'h0000_0200, 1,0));
      vecs.push_back(mk(0,0,0, 0, 0, 0, 0,0, 1, 9,0,  0,0, 32'h0000_0000, 0,0));
      vecs.push_back(mk(1,1,0,10, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_0400, 1,0));
      vecs.push_back(mk(1,1,0,11, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_0C00, 2,0));
      vecs.push_back(mk(1,1,0,12, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_1C00, 3,0));
      vecs.push_back(mk(1,1,0,13, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_3C00, 4,0));
      vecs.push_back(mk(1,1,0,14, 0, 0, 0,0, 0, 0,0,  1,0, 32'h0000_3C00, 4,0));
      vecs.push_back(mk(1,0,0,14, 1, 0, 1,0, 0, 0,0,  0,1, 32'h0000_3C00, 4,0));
      vecs.push_back(mk(0,0,0, 0, 0, 0, 0,0, 1,20,0,  0,0, 32'h0000_3C00, 4,1));
      vecs.push_back(mk(0,0,0, 0, 0, 0, 0,0, 0, 0,1,  0,0, 32'h0000_0000, 0,1));
      vecs.push_back(mk(1,1,0, 3, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_0008, 1,1));
      vecs.push_back(mk(1,1,0, 4, 0, 0, 0,0, 0, 0,0,  0,1, 32'h0000_0018, 2,1));
      vecs.push_back(mk(0,0,0, 0, 3, 4, 1,1, 0, 0,0,  0,0, 32'h0000_0018, 2,1));
      vecs.push_back(mk(1,1,0, 6, 0, 0, 0,0, 0, 0,1,  0,1, 32'h0000_0000, 0,1));

      foreach (vecs[k]) begin
         iss_valid_i = vecs[k].v; iss_regwrite_i = vecs[k].rw; iss_isjal_i = vecs[k].jal;
         iss_rd_i = vecs[k].rd; iss_rs_i = vecs[k].rs; iss_rt_i = vecs[k].rt;
         iss_use_rs_i = vecs[k].urs; iss_use_rt_i = vecs[k].urt;
         wb_valid_i = vecs[k].wv; wb_rd_i = vecs[k].wrd; flush_i = vecs[k].fl;
         #1;
         chk($sformatf("vec%0d_stall", k), 32'(stall_o), 32'(vecs[k].e_stall));
         chk($sformatf("vec%0d_accept", k), 32'(iss_accept_o), 32'(vecs[k].e_acc));
         @(posedge clk_i); #1;
         chk($sformatf("vec%0d_busy", k), busy_o, vecs[k].e_busy);
         chk($sformatf("vec%0d_out", k), 32'(outstanding_o), 32'(vecs[k].e_out));
         chk($sformatf("vec%0d_err", k), 32'(err_o), 32'(vecs[k].e_err));
      end

      // Asynchronous reset mid-cycle with pending writes and sticky error.
      idle_inputs();
      iss_valid_i = 1; iss_regwrite_i = 1; iss_rd_i = 7;
      @(posedge clk_i); #1;
      idle_inputs();
      chk("pre_rst_busy", busy_o, 32'h0000_0080);
      #2 rst_i = 1;
      #1;
      chk("midrst_busy", busy_o, 32'h0);
      chk("midrst_out", 32'(outstanding_o), 0);
      chk("midrst_err", 32'(err_o), 0);
      @(posedge clk_i); #1;
      rst_i = 0;

      // Randomized run against the counter model.
      model_clear();
      for (int c = 0; c < 3000; c++) begin
         bit exp_stall;
         int start;
         iss_valid_i    = ($urandom % 4) != 0;
         iss_regwrite_i = $urandom % 2;
         iss_isjal_i    = ($urandom % 10) == 0;
         iss_rd_i       = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 8);
         iss_rs_i       = 5'($urandom % 8);
         iss_rt_i       = 5'($urandom % 8);
         iss_use_rs_i   = $urandom % 2;
         iss_use_rt_i   = $urandom % 2;
         wb_valid_i     = ($urandom % 5) < 2;
         wb_rd_i        = 5'($urandom % 32);
         if ($urandom % 8 != 0) begin
            start = $urandom % 32;
            for (int j = 0; j < 32; j++)
               if (m_cnt[(start + j) % 32] > 0) wb_rd_i = 5'((start + j) % 32);
         end
         flush_i        = ($urandom % 40) == 0;
         #1;
         exp_stall = model_stall();
         chk("rnd_stall", 32'(stall_o), 32'(exp_stall));
         chk("rnd_accept", 32'(iss_accept_o), 32'(iss_valid_i && !exp_stall));
         @(posedge clk_i);
         model_step(iss_valid_i && !exp_stall);
         #1;
         chk("rnd_busy", busy_o, model_busy());
         chk("rnd_out", 32'(outstanding_o), 32'(m_out));
         chk("rnd_err", 32'(err_o), 32'(m_err));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
